// File: rtl/score_scan_controller.sv
// Score / high-score keeper and 4-digit seven-segment scan sequencer.
// Ports:
//   clk, rst_n        : clock, async active-low reset
//   eat, game_reset   : one-cycle pulses from the game FSM
//   show_high         : 1 = show high score, 0 = show current score
//   hundreds/tens/ones: BCD digits of disp_value from score_display
//   disp_value        : binary value sent to score_display
//   score, high_score : score registers
//   new_high          : high score beaten during this game
//   an, seg, dp       : active-low anodes, segments {g..a}, decimal point
module score_scan_controller #(
    parameter int SCAN_DIV  = 100000,
    parameter int BLINK_DIV = 25000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       eat,
    input  logic       game_reset,
    input  logic       show_high,
    input  logic [3:0] hundreds,
    input  logic [3:0] tens,
    input  logic [3:0] ones,
    output logic [7:0] disp_value,
    output logic [7:0] score,
    output logic [7:0] high_score,
    output logic       new_high,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [SCAN_W-1:0]  SCAN_MAX  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_DIV - 1);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_H     = 7'b0001001;

    typedef enum logic [1:0] {
        DIG_ONES  = 2'd0,
        DIG_TENS  = 2'd1,
        DIG_HUNDS = 2'd2,
        DIG_MODE  = 2'd3
    } digit_e;

    logic [7:0]         score_q, score_d;
    logic [7:0]         high_q, high_d;
    logic               new_high_q, new_high_d;
    logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
    digit_e             digit_q, digit_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_off_q, blink_off_d;
    logic [3:0]         an_q, an_d;
    logic [6:0]         seg_q, seg_d;

    logic               blink_active;
    logic               blink_dark;
    logic [3:0]         an_sel;
    logic [6:0]         seg_sel;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Score and high-score tracking
    always_comb begin
        score_d    = score_q;
        high_d     = high_q;
        new_high_d = new_high_q;

        if (game_reset) begin
            score_d = 8'd0;
        end else if (eat && (score_q != 8'hFF)) begin
            score_d = score_q + 8'd1;
        end

        // Compares registered values, so high_score trails score by a cycle
        if (score_q > high_q) begin
            high_d     = score_q;
            new_high_d = 1'b1;
        end

        if (game_reset) begin
            new_high_d = 1'b0;
        end
    end

    // Scan counter and digit index
    always_comb begin
        scan_cnt_d = scan_cnt_q + SCAN_W'(1);
        digit_d    = digit_q;
        if (scan_cnt_q == SCAN_MAX) begin
            scan_cnt_d = '0;
            unique case (digit_q)
                DIG_ONES:  digit_d = DIG_TENS;
                DIG_TENS:  digit_d = DIG_HUNDS;
                DIG_HUNDS: digit_d = DIG_MODE;
                DIG_MODE:  digit_d = DIG_ONES;
                default:   digit_d = DIG_ONES;
            endcase
        end
    end

    // Blink only while a fresh record is shown on the live score;
    // otherwise the timer is parked so re-entry starts in the on phase.
    assign blink_active = new_high_q & ~show_high;
    assign blink_dark   = blink_active & blink_off_q;

    always_comb begin
        blink_cnt_d = '0;
        blink_off_d = 1'b0;
        if (blink_active) begin
            if (blink_cnt_q == BLINK_MAX) begin
                blink_cnt_d = '0;
                blink_off_d = ~blink_off_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BLINK_W'(1);
                blink_off_d = blink_off_q;
            end
        end
    end

    // Digit content with leading-zero blanking
    always_comb begin
        an_sel  = 4'b1111;
        seg_sel = SEG_BLANK;
        unique case (digit_q)
            DIG_ONES: begin
                an_sel  = 4'b1110;
                seg_sel = bcd_to_seg(ones);
            end
            DIG_TENS: begin
                an_sel  = 4'b1101;
                if ((hundreds != 4'd0) || (tens != 4'd0)) begin
                    seg_sel = bcd_to_seg(tens);
                end
            end
            DIG_HUNDS: begin
                an_sel  = 4'b1011;
                if (hundreds != 4'd0) begin
                    seg_sel = bcd_to_seg(hundreds);
                end
            end
            DIG_MODE: begin
                an_sel  = 4'b0111;
                if (show_high) begin
                    seg_sel = SEG_H;
                end
            end
            default: begin
                an_sel  = 4'b1111;
                seg_sel = SEG_BLANK;
            end
        endcase
    end

    // an and seg share one register stage so they always match
    always_comb begin
        an_d  = blink_dark ? 4'b1111 : an_sel;
        seg_d = seg_sel;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            score_q     <= 8'd0;
            high_q      <= 8'd0;
            new_high_q  <= 1'b0;
            scan_cnt_q  <= '0;
            digit_q     <= DIG_ONES;
            blink_cnt_q <= '0;
            blink_off_q <= 1'b0;
            an_q        <= 4'b1111;
            seg_q       <= SEG_BLANK;
        end else begin
            score_q     <= score_d;
            high_q      <= high_d;
            new_high_q  <= new_high_d;
            scan_cnt_q  <= scan_cnt_d;
            digit_q     <= digit_d;
            blink_cnt_q <= blink_cnt_d;
            blink_off_q <= blink_off_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
        end
    end

    assign disp_value = show_high ? high_q : score_q;
    assign score      = score_q;
    assign high_score = high_q;
    assign new_high   = new_high_q;
    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = 1'b1;

endmodule

// File: tb/tb_score_scan_controller.sv
// Directed self-checking bench for score_scan_controller.
// Includes a behavioural binary-to-BCD converter in place of score_display.
module tb_score_scan_controller;

    logic       clk;
    logic       rst_n;
    logic       eat;
    logic       game_reset;
    logic       show_high;
    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] ones;
    logic [7:0] disp_value;
    logic [7:0] score;
    logic [7:0] high_score;
    logic       new_high;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S6 = 7'b0000010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] SB = 7'b1111111;
    localparam logic [6:0] SH = 7'b0001001;

    score_scan_controller #(
        .SCAN_DIV  (4),
        .BLINK_DIV (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .eat        (eat),
        .game_reset (game_reset),
        .show_high  (show_high),
        .hundreds   (hundreds),
        .tens       (tens),
        .ones       (ones),
        .disp_value (disp_value),
        .score      (score),
        .high_score (high_score),
        .new_high   (new_high),
        .an         (an),
        .seg        (seg),
        .dp         (dp)
    );

    always_comb begin
        hundreds = 4'(disp_value / 8'd100);
        tens     = 4'((disp_value / 8'd10) % 8'd10);
        ones     = 4'(disp_value % 8'd10);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic eat_n(input int n);
        eat = 1'b1;
        repeat (n) tick();
        eat = 1'b0;
    endtask

    task automatic chk_digit(input string tag, input logic [3:0] pat,
                             input logic [6:0] exp);
        int k;
        k = 0;
        while (an !== pat && k < 64) begin
            tick();
            k++;
        end
        chk({tag, "_an"}, 32'(an), 32'(pat));
        chk({tag, "_seg"}, 32'(seg), 32'(exp));
    endtask

    task automatic blink_halves(output int off_len, output int on_len);
        int k;
        k = 0;
        while (an === 4'b1111 && k < 64) begin tick(); k++; end
        k = 0;
        while (an !== 4'b1111 && k < 64) begin tick(); k++; end
        off_len = 0;
        while (an === 4'b1111 && off_len < 64) begin tick(); off_len++; end
        on_len = 0;
        while (an !== 4'b1111 && on_len < 64) begin tick(); on_len++; end
    endtask

    initial begin
        int off_len;
        int on_len;
        int dark;

        rst_n      = 1'b0;
        eat        = 1'b0;
        game_reset = 1'b0;
        show_high  = 1'b0;
        tick();
        tick();

        chk("rst_an", 32'(an), 32'(4'b1111));
        chk("rst_seg", 32'(seg), 32'(SB));
        chk("rst_dp", 32'(dp), 32'd1);
        chk("rst_score", 32'(score), 32'd0);
        chk("rst_high", 32'(high_score), 32'd0);
        chk("rst_new_high", 32'(new_high), 32'd0);

        // 1: idle scan, score 0
        rst_n = 1'b1;
        tick();
        chk("t1_an0", 32'(an), 32'(4'b1110));
        chk("t1_seg0", 32'(seg), 32'(S0));
        tick(); tick(); tick();
        chk("t1_an0_hold", 32'(an), 32'(4'b1110));
        tick();
        chk("t1_an1", 32'(an), 32'(4'b1101));
        chk("t1_seg1", 32'(seg), 32'(SB));
        repeat (4) tick();
        chk("t1_an2", 32'(an), 32'(4'b1011));
        chk("t1_seg2", 32'(seg), 32'(SB));
        repeat (4) tick();
        chk("t1_an3", 32'(an), 32'(4'b0111));
        chk("t1_seg3", 32'(seg), 32'(SB));
        repeat (4) tick();
        chk("t1_an_wrap", 32'(an), 32'(4'b1110));

        // 2: 36 eats, high score lag, blinking record
        eat_n(36);
        chk("t2_score", 32'(score), 32'd36);
        chk("t2_high_lag", 32'(high_score), 32'd35);
        tick();
        chk("t2_high", 32'(high_score), 32'd36);
        chk("t2_new_high", 32'(new_high), 32'd1);
        chk_digit("t2_ones", 4'b1110, S6);
        chk_digit("t2_tens", 4'b1101, S3);
        chk_digit("t2_hund", 4'b1011, SB);
        blink_halves(off_len, on_len);
        chk("t2_blink_off", 32'(off_len), 32'd16);
        chk("t2_blink_on", 32'(on_len), 32'd16);

        // 3: reach 107, new game, then view high score
        eat_n(71);
        tick();
        chk("t3_score", 32'(score), 32'd107);
        chk("t3_high", 32'(high_score), 32'd107);
        game_reset = 1'b1;
        tick();
        game_reset = 1'b0;
        chk("t3_score_clr", 32'(score), 32'd0);
        chk("t3_high_keep", 32'(high_score), 32'd107);
        chk("t3_new_high_clr", 32'(new_high), 32'd0);
        tick(); tick();
        dark = 0;
        repeat (20) begin
            if (an === 4'b1111) dark++;
            tick();
        end
        chk("t3_no_blink", 32'(dark), 32'd0);
        show_high = 1'b1;
        #1;
        chk("t3_disp_value", 32'(disp_value), 32'd107);
        tick();
        chk_digit("t3_ones", 4'b1110, S7);
        chk_digit("t3_tens", 4'b1101, S0);
        chk_digit("t3_hund", 4'b1011, S1);
        chk_digit("t3_mode", 4'b0111, SH);

        // 4: saturation at 255
        eat_n(260);
        tick();
        chk("t4_score_sat", 32'(score), 32'd255);
        chk("t4_high_sat", 32'(high_score), 32'd255);
        chk("t4_new_high", 32'(new_high), 32'd1);
        chk_digit("t4_ones", 4'b1110, S5);
        chk_digit("t4_tens", 4'b1101, S5);
        chk_digit("t4_hund", 4'b1011, S2);
        chk_digit("t4_mode", 4'b0111, SH);
        show_high = 1'b0;
        tick();
        chk_digit("t4_mode_live", 4'b0111, SB);
        chk_digit("t4_hund_live", 4'b1011, S2);

        // 5: eat and game_reset together
        game_reset = 1'b1;
        tick();
        game_reset = 1'b0;
        eat_n(5);
        chk("t5_score5", 32'(score), 32'd5);
        eat        = 1'b1;
        game_reset = 1'b1;
        tick();
        eat        = 1'b0;
        game_reset = 1'b0;
        chk("t5_score_clr", 32'(score), 32'd0);
        tick();
        chk("t5_score_hold", 32'(score), 32'd0);
        chk("t5_high_keep", 32'(high_score), 32'd255);

        // 6: asynchronous reset mid-scan
        eat_n(3);
        tick(); tick();
        rst_n = 1'b0;
        #1;
        chk("t6_an", 32'(an), 32'(4'b1111));
        chk("t6_seg", 32'(seg), 32'(SB));
        chk("t6_score", 32'(score), 32'd0);
        chk("t6_high", 32'(high_score), 32'd0);
        chk("t6_new_high", 32'(new_high), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("t6_resume_an", 32'(an), 32'(4'b1110));
        chk("t6_resume_seg", 32'(seg), 32'(S0));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
